// File: rtl/capture_pkg.sv
// Shared types and constants for the ADC capture engine.
package capture_pkg;

  localparam int unsigned CAP_DEPTH  = 512;
  localparam int unsigned CAP_ADDR_W = 9;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } cap_state_e;

  // DONE is reported on the 2-bit state port as IDLE; done flags it instead.
  function automatic logic [1:0] state_code(cap_state_e s);
    return (s == DONE) ? 2'd0 : s[1:0];
  endfunction

endpackage

// File: rtl/capture_trigger.sv
// Level-crossing trigger detector for the capture engine.
// Evaluates each kept sample against the previous kept sample (or, with
// CAPTURE_TRIG_HYST_EN defined, against a hysteresis re-arm state) and
// produces a registered one-cycle trig_hit_o aligned with that sample.
module capture_trigger #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                kept_i,
  input  logic signed [W-1:0] sample_i,
  input  logic signed [W-1:0] level_i,
  input  logic                edge_i,
  input  logic                force_i,
`ifdef CAPTURE_TRIG_HYST_EN
  input  logic [15:0]         hyst_i,
`endif
  output logic                trig_hit_o
);

  logic edge_hit;

`ifdef CAPTURE_TRIG_HYST_EN
  logic              armed_q;
  logic signed [W:0] level_x, hyst_x, thr_x, sample_x;
  logic              rearm;

  assign level_x  = {level_i[W-1], level_i};
  assign hyst_x   = signed'((W+1)'(hyst_i));
  assign sample_x = {sample_i[W-1], sample_i};
  assign thr_x    = edge_i ? (level_x + hyst_x) : (level_x - hyst_x);
  assign rearm    = edge_i ? (sample_x > thr_x) : (sample_x < thr_x);
  assign edge_hit = armed_q && (edge_i ? (sample_i <= level_i) : (sample_i >= level_i));

  // Re-arm tracking: set beyond the hysteresis threshold, cleared on fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else if (clear_i) begin
      armed_q <= 1'b0;
    end else if (kept_i) begin
      armed_q <= edge_hit ? 1'b0 : (armed_q | rearm);
    end
  end
`else
  logic signed [W-1:0] prev_q;
  logic                prev_vld_q;

  assign edge_hit = prev_vld_q &&
                    (edge_i ? (prev_q > level_i && sample_i <= level_i)
                            : (prev_q < level_i && sample_i >= level_i));

  // Previous kept sample, invalidated on arm so the first sample cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (clear_i) begin
      prev_vld_q <= 1'b0;
    end else if (kept_i) begin
      prev_q     <= sample_i;
      prev_vld_q <= 1'b1;
    end
  end
`endif

  // One-cycle hit registered alongside the kept sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_hit_o <= 1'b0;
    end else if (clear_i) begin
      trig_hit_o <= 1'b0;
    end else begin
      trig_hit_o <= kept_i & (force_i | edge_hit);
    end
  end

endmodule

// File: rtl/adc_capture_engine.sv
// Triggered waveform capture: decimator, capture FSM, circular write pointer,
// block RAM and window-relative read port.
// Optional macro CAPTURE_TRIG_HYST_EN adds the trig_hyst input and hysteresis.
module adc_capture_engine
  import capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic [15:0]           decim,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  trig_edge,
  input  logic                  trig_force,
`ifdef CAPTURE_TRIG_HYST_EN
  input  logic [15:0]           trig_hyst,
`endif
  input  logic [ADDR_WIDTH-1:0] pre_count,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_index,
  output logic [1:0]            state
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  cap_state_e                   state_q;
  logic [15:0]                  decim_q, dcnt_q;
  logic signed [DATA_WIDTH-1:0] level_q;
  logic                         edge_q;
  logic [ADDR_WIDTH-1:0]        pre_q, wr_ptr_q, trig_ptr_q, rd_ptr;
  logic [ADDR_WIDTH:0]          cnt_q, cnt_inc, post_len;
  logic [DATA_WIDTH-1:0]        sample_q;
  logic                         kept_q, keep, active, arm_ok, wr_en, trig_hit;
  logic [DATA_WIDTH-1:0]        mem [0:(1<<ADDR_WIDTH)-1];
`ifdef CAPTURE_TRIG_HYST_EN
  logic [15:0]                  hyst_q;
`endif

  assign active   = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign arm_ok   = arm && !abort && ((state_q == IDLE) || (state_q == DONE));
  assign keep     = active && adc_valid && (dcnt_q == decim_q);
  assign wr_en    = kept_q && active;
  assign cnt_inc  = cnt_q + ONE_L;
  assign post_len = DEPTH_L - {1'b0, pre_q};
  assign rd_ptr   = trig_ptr_q - pre_q + rd_addr;

  assign busy       = active;
  assign done       = (state_q == DONE);
  assign state      = state_code(state_q);
  assign trig_index = pre_q;

  // Capture configuration, frozen for the duration of a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim_q <= '0;
      level_q <= '0;
      edge_q  <= 1'b0;
      pre_q   <= '0;
`ifdef CAPTURE_TRIG_HYST_EN
      hyst_q  <= '0;
`endif
    end else if (arm_ok) begin
      decim_q <= decim;
      level_q <= trig_level;
      edge_q  <= trig_edge;
      pre_q   <= pre_count;
`ifdef CAPTURE_TRIG_HYST_EN
      hyst_q  <= trig_hyst;
`endif
    end
  end

  // Decimator: keep one of every decim+1 valid samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
    end else if (arm_ok) begin
      dcnt_q <= '0;
    end else if (active && adc_valid) begin
      dcnt_q <= (dcnt_q == decim_q) ? '0 : dcnt_q + 16'd1;
    end
  end

  // Kept-sample stage; the trigger verdict for this sample lands in trig_hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kept_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      kept_q <= keep;
      if (keep) sample_q <= adc_data;
    end
  end

  capture_trigger #(.W(DATA_WIDTH)) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (arm_ok),
    .kept_i     (keep),
    .sample_i   (adc_data),
    .level_i    (level_q),
    .edge_i     (edge_q),
    .force_i    (trig_force),
`ifdef CAPTURE_TRIG_HYST_EN
    .hyst_i     (hyst_q),
`endif
    .trig_hit_o (trig_hit)
  );

  // Circular write pointer; never reset by arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else if (wr_en) begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // Sample buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_q;
  end

  // Registered read, addressed relative to the window start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_ptr];
    end
  end

  // Capture FSM; decisions are taken on the write of each kept sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trig_ptr_q <= '0;
    end else if (abort) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            cnt_q   <= '0;
            state_q <= (pre_count == '0) ? WAIT_TRIG : PRE;
          end
        end
        PRE: begin
          if (wr_en) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == {1'b0, pre_q}) state_q <= WAIT_TRIG;
          end
        end
        WAIT_TRIG: begin
          if (wr_en && trig_hit) begin
            trig_ptr_q <= wr_ptr_q;
            cnt_q      <= ONE_L;
            state_q    <= (post_len == ONE_L) ? DONE : POST;
          end
        end
        POST: begin
          if (wr_en) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == post_len) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_engine.sv
// Scoreboard bench for adc_capture_engine: read requests push expected data,
// a negedge monitor pops and compares when the registered read data appears.
module tb_adc_capture_engine;

  logic        clk = 1'b0;
  logic        rst_n, arm, abort, adc_valid, trig_edge, trig_force;
  logic [15:0] adc_data, decim, trig_level, rd_data;
  logic [8:0]  pre_count, rd_addr, trig_index;
  logic        busy, done;
  logic [1:0]  state;
`ifdef CAPTURE_TRIG_HYST_EN
  logic [15:0] trig_hyst;
`endif

  always #5 clk = ~clk;

  adc_capture_engine #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .decim      (decim),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .trig_force (trig_force),
`ifdef CAPTURE_TRIG_HYST_EN
    .trig_hyst  (trig_hyst),
`endif
    .pre_count  (pre_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .done       (done),
    .trig_index (trig_index),
    .state      (state)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int    exp;
    string name;
  } rd_exp_t;
  rd_exp_t rdq[$];

  logic rd_issue = 1'b0;
  logic rd_vld   = 1'b0;

  always @(posedge clk) rd_vld <= rd_issue;

  // Monitor: one registered read result per issued request.
  always @(negedge clk) begin : mon
    rd_exp_t e;
    if (rd_vld) begin
      checks++;
      if (rdq.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected got=%0d want=none", $signed(rd_data));
      end else begin
        e = rdq.pop_front();
        if (int'($signed(rd_data)) != e.exp) begin
          failures++;
          $display("FAIL %s got=%0d want=%0d", e.name, $signed(rd_data), e.exp);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Stimulus patterns, indexed by kept-sample number.
  function automatic int sval(input int kind, input int i);
    case (kind)
      0:       return -1000 + i;
      1:       return i;
      2:       return 5000 + i;
      3:       return (i < 5) ? 1000 : (i < 10) ? 400 : (i == 10) ? 600 : 450 - (i - 11);
      4:       return (i < 20) ? (((i % 2) == 0) ? -50 : 50) : (i == 20) ? -150 : 10 + (i - 21);
      default: return -3000 + i;
    endcase
  endfunction

  task automatic stream(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'(sval(kind, i));
      @(posedge clk); #1;
    end
    adc_valid = 1'b0;
  endtask

  task automatic arm_cap(input int dcm, input int lvl, input logic edg,
                         input logic frc, input int pre);
    decim      = 16'(dcm);
    trig_level = 16'(lvl);
    trig_edge  = edg;
    trig_force = frc;
    pre_count  = 9'(pre);
    arm        = 1'b1;
    @(posedge clk); #1;
    arm        = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, int'(done), 1);
  endtask

  task automatic rd_req(input int a, input int exp, input string name);
    rd_addr  = 9'(a);
    rd_issue = 1'b1;
    rdq.push_back('{exp, name});
    @(posedge clk); #1;
    rd_issue = 1'b0;
  endtask

  task automatic drain();
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; adc_valid = 1'b0; adc_data = '0;
    decim = '0; trig_level = '0; trig_edge = 1'b0; trig_force = 1'b0;
    pre_count = '0; rd_addr = '0;
`ifdef CAPTURE_TRIG_HYST_EN
    trig_hyst = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_trig_index", int'(trig_index), 0);
    check("rst_state", int'(state), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Rising capture on a ramp; trig_level changed after arm must not matter.
    arm_cap(0, 0, 1'b0, 1'b0, 100);
    check("t1_busy_on_arm", int'(busy), 1);
    check("t1_state_pre", int'(state), 1);
    trig_level = 16'(5000);
    stream(0, 2001);
    check("t1_done", int'(done), 1);
    check("t1_busy_end", int'(busy), 0);
    check("t1_state_end", int'(state), 0);
    check("t1_trig_index", int'(trig_index), 100);
    rd_req(100, 0, "t1_rd100");
    rd_req(99, -1, "t1_rd99");
    rd_req(0, -100, "t1_rd0");
    rd_req(511, 411, "t1_rd511");
    drain();

    // Decimation by 4, forced trigger on the first kept sample.
    arm_cap(3, 0, 1'b0, 1'b1, 0);
    check("t2_state_wait", int'(state), 2);
    check("t2_done_cleared", int'(done), 0);
    stream(1, 2048);
    wait_done("t2_done", 4);
    check("t2_trig_index", int'(trig_index), 0);
    rd_req(0, 3, "t2_rd0");
    rd_req(1, 7, "t2_rd1");
    rd_req(2, 11, "t2_rd2");
    rd_req(511, 2047, "t2_rd511");
    drain();

    // Back-to-back forced captures; window starts at physical 388 and wraps.
    arm_cap(0, 0, 1'b0, 1'b1, 0);
    stream(2, 512);
    check("t3_done_not_early", int'(done), 0);
    @(posedge clk); #1;
    check("t3_done_after_last", int'(done), 1);
    arm_cap(0, 0, 1'b0, 1'b1, 0);
    check("t3_rearm_done_clr", int'(done), 0);
    stream(5, 512);
    wait_done("t3b_done", 4);
    rd_req(0, -3000, "t3_rd0");
    rd_req(123, -2877, "t3_rd123");
    rd_req(124, -2876, "t3_rd124");
    rd_req(511, -2489, "t3_rd511");
    drain();

    // Abort in POST, then simultaneous arm and abort.
    arm_cap(0, 0, 1'b0, 1'b1, 0);
    stream(1, 50);
    check("t4_state_post", int'(state), 3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t4_abort_busy", int'(busy), 0);
    check("t4_abort_done", int'(done), 0);
    check("t4_abort_state", int'(state), 0);
    arm = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    check("t4_both_busy", int'(busy), 0);
    check("t4_both_done", int'(done), 0);
    check("t4_both_state", int'(state), 0);
    @(posedge clk); #1;
    check("t4_stay_idle", int'(state), 0);

    // Falling trigger; the crossing at kept sample 5 lies inside PRE.
    arm_cap(0, 500, 1'b1, 1'b0, 10);
    stream(3, 600);
    wait_done("t5_done", 4);
    check("t5_trig_index", int'(trig_index), 10);
    rd_req(10, 450, "t5_rd10");
    rd_req(9, 600, "t5_rd9");
    rd_req(4, 400, "t5_rd4");
    rd_req(0, 1000, "t5_rd0");
    rd_req(511, -51, "t5_rd511");
    drain();

`ifdef CAPTURE_TRIG_HYST_EN
    // Hysteresis: dither inside the band must not fire; dip then rise does.
    trig_hyst = 16'd100;
    arm_cap(0, 0, 1'b0, 1'b0, 0);
    stream(4, 600);
    wait_done("t6_done", 4);
    rd_req(0, 10, "t6_rd0");
    rd_req(1, 11, "t6_rd1");
    rd_req(511, 521, "t6_rd511");
    drain();
`endif

    checks++;
    if (rdq.size() != 0) begin
      failures++;
      $display("FAIL rd_pending got=%0d want=0", rdq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
